tracker_frame_sequencer: RTL and testbench

Controller between the frame-buffer pixel reader and the Tracker core, in the 25 MHz VGA clock domain. Aligns to start-of-frame and paces pixels into the Tracker at its minimum spacing. Optionally skips frames, then waits for the Tracker result with a timeout. Latches the tracked point for the overlay/VGA path and recovers cleanly from misaligned frames and missing results.

---
 rtl/tracker_frame_sequencer_pkg.sv | 7 +
 rtl/tracker_frame_sequencer_if.sv | 39 +++
 rtl/tracker_frame_sequencer_frame_pos_counter.sv | 35 +++
 rtl/tracker_frame_sequencer.sv | 170 +++++++++++++++++
 tb/tb_tracker_frame_sequencer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tracker_frame_sequencer_pkg.sv
// trk_seq_pkg: sequencer states, RGB width and default frame geometry
package trk_seq_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_SOF, SKIP, STREAM, WAIT_RESULT} state_e;
  localparam int RGB_W = 24;
  localparam int DEF_H_ACT = 640;
  localparam int DEF_V_ACT = 480;
endpackage

// File: rtl/tracker_frame_sequencer_if.sv
// tracker_frame_sequencer_if: control, pixel-source, tracker and result signals (slave = sequencer side, master = environment side)
interface tracker_frame_sequencer_if
  import trk_seq_pkg::*;
#(
  parameter int CW = 10,
  parameter int SKIP_W = 4
);
  logic i_start;
  logic i_stop;
  logic [SKIP_W-1:0] i_skip;
  logic [RGB_W-1:0] i_pix_rgb;
  logic i_pix_valid;
  logic i_pix_sof;
  logic o_pix_ready;
  logic [RGB_W-1:0] o_trk_rgb;
  logic o_trk_pixelVAL;
  logic o_trk_clear;
  logic [CW-1:0] i_trk_pointH;
  logic [CW-1:0] i_trk_pointV;
  logic i_trk_valid;
  logic [CW-1:0] o_pointH;
  logic [CW-1:0] o_pointV;
  logic o_point_valid;
  logic o_point_upd;
  logic o_busy;
  logic o_err_sof;
  logic o_err_timeout;
  logic [15:0] o_frame_cnt;
  modport slave (
    input i_start, i_stop, i_skip, i_pix_rgb, i_pix_valid, i_pix_sof, i_trk_pointH, i_trk_pointV, i_trk_valid,
    output o_pix_ready, o_trk_rgb, o_trk_pixelVAL, o_trk_clear, o_pointH, o_pointV, o_point_valid, o_point_upd,
    output o_busy, o_err_sof, o_err_timeout, o_frame_cnt
  );
  modport master (
    output i_start, i_stop, i_skip, i_pix_rgb, i_pix_valid, i_pix_sof, i_trk_pointH, i_trk_pointV, i_trk_valid,
    input o_pix_ready, o_trk_rgb, o_trk_pixelVAL, o_trk_clear, o_pointH, o_pointV, o_point_valid, o_point_upd,
    input o_busy, o_err_sof, o_err_timeout, o_frame_cnt
  );
endinterface

// File: rtl/tracker_frame_sequencer_frame_pos_counter.sv
// frame_pos_counter: h/v position of the next counted pixel (clk, rst_n, adv_i, sof_i restarts at 0,0; last_o, origin_o)
module frame_pos_counter
  import trk_seq_pkg::*;
#(
  parameter int H_ACT = DEF_H_ACT,
  parameter int V_ACT = DEF_V_ACT,
  parameter int CW = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic adv_i,
  input  logic sof_i,
  output logic last_o,
  output logic origin_o
);
  logic [CW-1:0] h_q, h_d, v_q, v_d, ch, cv;
  logic eol;
  always_comb begin
    ch = sof_i ? '0 : h_q;
    cv = sof_i ? '0 : v_q;
    eol = ch == CW'(H_ACT - 1);
    last_o = eol && cv == CW'(V_ACT - 1);
    origin_o = h_q == '0 && v_q == '0;
    h_d = !adv_i ? h_q : eol ? '0 : ch + 1'b1;
    v_d = !adv_i ? v_q : !eol ? cv : last_o ? '0 : cv + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
endmodule

// File: rtl/tracker_frame_sequencer.sv
// tracker_frame_sequencer: SOF-aligned, gap-paced pixel feed into the Tracker with frame skip and result timeout (i_clk, i_rst_n, bus.slave)
module tracker_frame_sequencer
  import trk_seq_pkg::*;
#(
  parameter int H_ACT = DEF_H_ACT,
  parameter int V_ACT = DEF_V_ACT,
  parameter int CW = 10,
  parameter int PIX_GAP = 2,
  parameter int TIMEOUT = 4096,
  parameter int SKIP_W = 4
) (
  input logic i_clk,
  input logic i_rst_n,
  tracker_frame_sequencer_if.slave bus
);
  localparam int GW = $clog2(PIX_GAP + 2);
  localparam int TW = $clog2(TIMEOUT);
  state_e state_q, state_d, reeval;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic [CW-1:0] ph_q, ph_d, pv_q, pv_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic stop_q, stop_d, pix_val_q, pix_val_d, clear_q, clear_d, upd_q, upd_d;
  logic pvalid_q, pvalid_d, err_sof_q, err_sof_d, err_tmo_q, err_tmo_d;
  logic ready, acc, sof, mis, last, origin, stop, fwd;
  assign ready = state_q == WAIT_SOF || state_q == SKIP || (state_q == STREAM && gap_q == '0);
  assign acc = bus.i_pix_valid && ready;
  assign sof = acc && bus.i_pix_sof;
  assign mis = sof && !origin;
  assign stop = stop_q || bus.i_stop;
  assign reeval = skip_q != '0 ? SKIP : STREAM;
  frame_pos_counter #(.H_ACT(H_ACT), .V_ACT(V_ACT), .CW(CW)) u_pos (
    .clk(i_clk),
    .rst_n(i_rst_n),
    .adv_i(acc && (state_q != WAIT_SOF || bus.i_pix_sof)),
    .sof_i(bus.i_pix_sof),
    .last_o(last),
    .origin_o(origin)
  );
  always_comb begin
    state_d = state_q;
    skip_d = skip_q;
    gap_d = gap_q != '0 ? gap_q - 1'b1 : '0;
    tmo_d = tmo_q;
    stop_d = stop_q;
    rgb_d = rgb_q;
    pix_val_d = 1'b0;
    clear_d = 1'b0;
    upd_d = 1'b0;
    pvalid_d = pvalid_q;
    err_sof_d = err_sof_q;
    err_tmo_d = err_tmo_q;
    ph_d = ph_q;
    pv_d = pv_q;
    fcnt_d = fcnt_q;
    fwd = 1'b0;
    case (state_q)
      IDLE: if (bus.i_start && !bus.i_stop) begin
        state_d = WAIT_SOF;
        skip_d = bus.i_skip;
        stop_d = 1'b0;
        err_sof_d = 1'b0;
        err_tmo_d = 1'b0;
        pvalid_d = 1'b0;
        fcnt_d = '0;
        ph_d = '0;
        pv_d = '0;
      end
      WAIT_SOF: if (stop) state_d = IDLE;
        else if (sof) begin
          state_d = reeval;
          fwd = skip_q == '0;
        end
      SKIP: if (stop) state_d = IDLE;
        else if (mis) begin
          err_sof_d = 1'b1;
          clear_d = 1'b1;
          state_d = reeval;
          fwd = skip_q == '0;
        end else if (acc && last) begin
          skip_d = skip_q - 1'b1;
          state_d = WAIT_SOF;
        end
      STREAM: begin
        stop_d = stop;
        if (mis) begin
          err_sof_d = 1'b1;
          clear_d = 1'b1;
          state_d = reeval;
          fwd = skip_q == '0;
        end else if (acc) begin
          fwd = 1'b1;
          state_d = last ? WAIT_RESULT : STREAM;
          tmo_d = '0;
        end
      end
      WAIT_RESULT: begin
        stop_d = stop;
        tmo_d = tmo_q + 1'b1;
        if (bus.i_trk_valid) begin
          ph_d = bus.i_trk_pointH > CW'(H_ACT - 1) ? CW'(H_ACT - 1) : bus.i_trk_pointH;
          pv_d = bus.i_trk_pointV > CW'(V_ACT - 1) ? CW'(V_ACT - 1) : bus.i_trk_pointV;
          upd_d = 1'b1;
          pvalid_d = 1'b1;
          fcnt_d = fcnt_q + 16'd1;
          skip_d = bus.i_skip;
          state_d = stop ? IDLE : WAIT_SOF;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_tmo_d = 1'b1;
          clear_d = 1'b1;
          state_d = stop ? IDLE : WAIT_SOF;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fwd) begin
      pix_val_d = 1'b1;
      rgb_d = bus.i_pix_rgb;
      gap_d = GW'(PIX_GAP);
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= IDLE;
      skip_q <= '0;
      gap_q <= '0;
      tmo_q <= '0;
      stop_q <= 1'b0;
      rgb_q <= '0;
      pix_val_q <= 1'b0;
      clear_q <= 1'b0;
      upd_q <= 1'b0;
      pvalid_q <= 1'b0;
      err_sof_q <= 1'b0;
      err_tmo_q <= 1'b0;
      ph_q <= '0;
      pv_q <= '0;
      fcnt_q <= '0;
    end else begin
      state_q <= state_d;
      skip_q <= skip_d;
      gap_q <= gap_d;
      tmo_q <= tmo_d;
      stop_q <= stop_d;
      rgb_q <= rgb_d;
      pix_val_q <= pix_val_d;
      clear_q <= clear_d;
      upd_q <= upd_d;
      pvalid_q <= pvalid_d;
      err_sof_q <= err_sof_d;
      err_tmo_q <= err_tmo_d;
      ph_q <= ph_d;
      pv_q <= pv_d;
      fcnt_q <= fcnt_d;
    end
  assign bus.o_pix_ready = ready;
  assign bus.o_trk_rgb = rgb_q;
  assign bus.o_trk_pixelVAL = pix_val_q;
  assign bus.o_trk_clear = clear_q;
  assign bus.o_pointH = ph_q;
  assign bus.o_pointV = pv_q;
  assign bus.o_point_valid = pvalid_q;
  assign bus.o_point_upd = upd_q;
  assign bus.o_busy = state_q != IDLE;
  assign bus.o_err_sof = err_sof_q;
  assign bus.o_err_timeout = err_tmo_q;
  assign bus.o_frame_cnt = fcnt_q;
endmodule

// File: tb/tb_tracker_frame_sequencer.sv
// tb_tracker_frame_sequencer: directed scenario bench for the tracker frame sequencer on an 8x4 frame
module tb_tracker_frame_sequencer;
  localparam int H = 8;
  localparam int V = 4;
  localparam int NPIX = H * V;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  tracker_frame_sequencer_if #(.CW(10), .SKIP_W(4)) bus ();
  tracker_frame_sequencer #(.H_ACT(H), .V_ACT(V), .CW(10), .PIX_GAP(2), .TIMEOUT(64), .SKIP_W(4)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );
  int tests = 0, fails = 0, cyc = 0;
  int n_pv, n_clr, n_upd, n_acc, frame_pv, min_gap, max_gap, last_pv_cyc, upd_cyc, tmo_cyc;
  int model_cnt = 0;
  logic [23:0] first_rgb, last_rgb;
  logic tmo_prev = 1'b0;
  logic trk_en = 1'b1;
  logic [9:0] trk_h = '0, trk_v = '0;
  logic sof_map [0:127];

  function automatic logic [23:0] rgb_of(input int i);
    return 24'hA50000 + 24'(i * 7 + 3);
  endfunction

  function automatic logic [68:0] all_outs();
    return {bus.o_pix_ready, bus.o_trk_rgb, bus.o_trk_pixelVAL, bus.o_trk_clear, bus.o_pointH, bus.o_pointV,
            bus.o_point_valid, bus.o_point_upd, bus.o_busy, bus.o_err_sof, bus.o_err_timeout, bus.o_frame_cnt};
  endfunction

  task automatic clear_obs();
    n_pv = 0; n_clr = 0; n_upd = 0; frame_pv = 0;
    min_gap = 1000000; max_gap = 0; last_pv_cyc = 0; upd_cyc = -1; tmo_cyc = -1;
    first_rgb = '0; last_rgb = '0;
  endtask

  task automatic tick();
    int g;
    @(posedge clk);
    #1;
    cyc++;
    bus.i_trk_valid = 1'b0;
    if (model_cnt > 0) begin
      model_cnt--;
      if (model_cnt == 0) begin
        bus.i_trk_valid = 1'b1;
        bus.i_trk_pointH = trk_h;
        bus.i_trk_pointV = trk_v;
      end
    end
    if (bus.o_trk_clear) begin
      n_clr++;
      frame_pv = 0;
    end
    if (bus.o_trk_pixelVAL) begin
      if (n_pv == 0) first_rgb = bus.o_trk_rgb;
      else begin
        g = cyc - last_pv_cyc;
        if (g < min_gap) min_gap = g;
        if (g > max_gap) max_gap = g;
      end
      last_rgb = bus.o_trk_rgb;
      last_pv_cyc = cyc;
      n_pv++;
      frame_pv++;
      if (frame_pv == NPIX) begin
        frame_pv = 0;
        if (trk_en) model_cnt = 10;
      end
    end
    if (bus.o_point_upd) begin
      n_upd++;
      upd_cyc = cyc;
    end
    if (bus.o_err_timeout && !tmo_prev) tmo_cyc = cyc;
    tmo_prev = bus.o_err_timeout;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_start(input int skip);
    bus.i_skip = 4'(skip);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.i_stop = 1'b1;
    tick();
    bus.i_stop = 1'b0;
  endtask

  task automatic drive(input int n, input int stop_at);
    int i = 0;
    int guard = 0;
    logic r;
    clear_obs();
    while (i < n && guard < 2000) begin
      bus.i_pix_valid = 1'b1;
      bus.i_pix_rgb = rgb_of(i);
      bus.i_pix_sof = sof_map[i];
      bus.i_stop = (i == stop_at);
      r = bus.o_pix_ready;
      tick();
      if (r) i++;
      guard++;
    end
    bus.i_pix_valid = 1'b0;
    bus.i_pix_sof = 1'b0;
    bus.i_stop = 1'b0;
    n_acc = i;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++; if (all_outs() !== '0) begin fails++; $display("FAIL reset_outs: got %h expected 0", all_outs()); end
    tests++; if (bus.o_pix_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", bus.o_pix_ready); end
    rst_n = 1'b1;
    tick();
    tests++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL reset_idle_busy: got %b expected 0", bus.o_busy); end
  endtask

  task automatic test_basic();
    trk_en = 1'b1; trk_h = 10'd5; trk_v = 10'd2;
    pulse_start(0);
    tests++; if (bus.o_pix_ready !== 1'b1) begin fails++; $display("FAIL basic_wait_ready: got %b expected 1", bus.o_pix_ready); end
    sof_map = '{default: 1'b0}; sof_map[0] = 1'b1;
    drive(NPIX, -1);
    idle(20);
    tests++; if (n_pv != NPIX) begin fails++; $display("FAIL basic_pulses: got %0d expected %0d", n_pv, NPIX); end
    tests++; if (min_gap != 3 || max_gap != 3) begin fails++; $display("FAIL basic_spacing: got min %0d max %0d expected 3", min_gap, max_gap); end
    tests++; if (first_rgb !== rgb_of(0) || last_rgb !== rgb_of(NPIX - 1)) begin fails++; $display("FAIL basic_rgb: got %h/%h expected %h/%h", first_rgb, last_rgb, rgb_of(0), rgb_of(NPIX - 1)); end
    tests++; if (bus.o_pointH !== 10'd5 || bus.o_pointV !== 10'd2) begin fails++; $display("FAIL basic_point: got %0d,%0d expected 5,2", bus.o_pointH, bus.o_pointV); end
    tests++; if (n_upd != 1 || upd_cyc - last_pv_cyc != 11) begin fails++; $display("FAIL basic_upd: got %0d pulses delay %0d expected 1 delay 11", n_upd, upd_cyc - last_pv_cyc); end
    tests++; if (bus.o_frame_cnt !== 16'd1 || bus.o_point_valid !== 1'b1) begin fails++; $display("FAIL basic_frame_cnt: got %0d valid %b expected 1 valid 1", bus.o_frame_cnt, bus.o_point_valid); end
    tests++; if (bus.o_busy !== 1'b1 || bus.o_pix_ready !== 1'b1) begin fails++; $display("FAIL basic_rearm: got busy %b ready %b expected 1 1", bus.o_busy, bus.o_pix_ready); end
  endtask

  task automatic test_junk_sof();
    trk_h = 10'd12; trk_v = 10'd9;
    sof_map = '{default: 1'b0}; sof_map[3] = 1'b1;
    drive(NPIX + 3, -1);
    idle(20);
    tests++; if (n_acc != NPIX + 3) begin fails++; $display("FAIL junk_accepted: got %0d expected %0d", n_acc, NPIX + 3); end
    tests++; if (n_pv != NPIX || first_rgb !== rgb_of(3)) begin fails++; $display("FAIL junk_first: got %0d pulses rgb %h expected %0d rgb %h", n_pv, first_rgb, NPIX, rgb_of(3)); end
    tests++; if (bus.o_pointH !== 10'd7 || bus.o_pointV !== 10'd3) begin fails++; $display("FAIL junk_clamp: got %0d,%0d expected 7,3", bus.o_pointH, bus.o_pointV); end
    tests++; if (bus.o_frame_cnt !== 16'd2) begin fails++; $display("FAIL junk_frame_cnt: got %0d expected 2", bus.o_frame_cnt); end
  endtask

  task automatic test_skip();
    pulse_stop();
    tests++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL skip_stop_idle: got %b expected 0", bus.o_busy); end
    trk_h = 10'd1; trk_v = 10'd1;
    pulse_start(2);
    bus.i_skip = 4'd0;
    tests++; if (bus.o_frame_cnt !== 16'd0 || bus.o_point_valid !== 1'b0) begin fails++; $display("FAIL skip_start_clear: got %0d valid %b expected 0 0", bus.o_frame_cnt, bus.o_point_valid); end
    sof_map = '{default: 1'b0}; sof_map[0] = 1'b1; sof_map[NPIX] = 1'b1; sof_map[2 * NPIX] = 1'b1;
    drive(3 * NPIX, -1);
    idle(20);
    tests++; if (n_pv != NPIX || first_rgb !== rgb_of(2 * NPIX)) begin fails++; $display("FAIL skip_tracked: got %0d pulses rgb %h expected %0d rgb %h", n_pv, first_rgb, NPIX, rgb_of(2 * NPIX)); end
    tests++; if (bus.o_frame_cnt !== 16'd1 || bus.o_pointH !== 10'd1 || bus.o_pointV !== 10'd1) begin fails++; $display("FAIL skip_result: got cnt %0d point %0d,%0d expected 1 1,1", bus.o_frame_cnt, bus.o_pointH, bus.o_pointV); end
    tests++; if (bus.o_err_sof !== 1'b0 || n_clr != 0) begin fails++; $display("FAIL skip_no_err: got err %b clears %0d expected 0 0", bus.o_err_sof, n_clr); end
  endtask

  task automatic test_misaligned();
    trk_h = 10'd3; trk_v = 10'd1;
    sof_map = '{default: 1'b0}; sof_map[0] = 1'b1; sof_map[13] = 1'b1;
    drive(13 + NPIX, -1);
    idle(20);
    tests++; if (bus.o_err_sof !== 1'b1 || n_clr != 1) begin fails++; $display("FAIL mis_err: got err %b clears %0d expected 1 1", bus.o_err_sof, n_clr); end
    tests++; if (n_pv != 13 + NPIX || last_rgb !== rgb_of(12 + NPIX)) begin fails++; $display("FAIL mis_pulses: got %0d rgb %h expected %0d rgb %h", n_pv, last_rgb, 13 + NPIX, rgb_of(12 + NPIX)); end
    tests++; if (n_upd != 1 || bus.o_frame_cnt !== 16'd2) begin fails++; $display("FAIL mis_result: got upd %0d cnt %0d expected 1 2", n_upd, bus.o_frame_cnt); end
    tests++; if (bus.o_pointH !== 10'd3 || bus.o_pointV !== 10'd1) begin fails++; $display("FAIL mis_point: got %0d,%0d expected 3,1", bus.o_pointH, bus.o_pointV); end
  endtask

  task automatic test_timeout();
    trk_en = 1'b0;
    sof_map = '{default: 1'b0}; sof_map[0] = 1'b1;
    drive(NPIX, -1);
    idle(80);
    tests++; if (bus.o_err_timeout !== 1'b1 || tmo_cyc - last_pv_cyc != 64) begin fails++; $display("FAIL tmo_flag: got %b delay %0d expected 1 delay 64", bus.o_err_timeout, tmo_cyc - last_pv_cyc); end
    tests++; if (n_clr != 1 || n_upd != 0) begin fails++; $display("FAIL tmo_clear: got clears %0d upd %0d expected 1 0", n_clr, n_upd); end
    tests++; if (bus.o_pointH !== 10'd3 || bus.o_pointV !== 10'd1 || bus.o_point_valid !== 1'b1) begin fails++; $display("FAIL tmo_point: got %0d,%0d valid %b expected 3,1 valid 1", bus.o_pointH, bus.o_pointV, bus.o_point_valid); end
    tests++; if (bus.o_frame_cnt !== 16'd2 || bus.o_busy !== 1'b1) begin fails++; $display("FAIL tmo_cnt: got %0d busy %b expected 2 1", bus.o_frame_cnt, bus.o_busy); end
    trk_en = 1'b1;
  endtask

  task automatic test_stop();
    trk_h = 10'd6; trk_v = 10'd3;
    sof_map = '{default: 1'b0}; sof_map[0] = 1'b1;
    drive(NPIX, 10);
    idle(20);
    tests++; if (n_pv != NPIX || n_upd != 1) begin fails++; $display("FAIL stop_complete: got %0d pulses %0d upd expected %0d 1", n_pv, n_upd, NPIX); end
    tests++; if (bus.o_pointH !== 10'd6 || bus.o_pointV !== 10'd3 || bus.o_frame_cnt !== 16'd3) begin fails++; $display("FAIL stop_result: got %0d,%0d cnt %0d expected 6,3 cnt 3", bus.o_pointH, bus.o_pointV, bus.o_frame_cnt); end
    tests++; if (bus.o_busy !== 1'b0 || bus.o_pix_ready !== 1'b0) begin fails++; $display("FAIL stop_idle: got busy %b ready %b expected 0 0", bus.o_busy, bus.o_pix_ready); end
    bus.i_start = 1'b1;
    bus.i_stop = 1'b1;
    tick();
    bus.i_start = 1'b0;
    bus.i_stop = 1'b0;
    tick();
    tests++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL start_stop_idle: got %b expected 0", bus.o_busy); end
  endtask

  task automatic test_async_reset();
    pulse_start(0);
    sof_map = '{default: 1'b0}; sof_map[0] = 1'b1;
    drive(10, -1);
    tests++; if (bus.o_busy !== 1'b1 || bus.o_trk_pixelVAL !== 1'b1) begin fails++; $display("FAIL arst_pre: got busy %b pv %b expected 1 1", bus.o_busy, bus.o_trk_pixelVAL); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (all_outs() !== '0) begin fails++; $display("FAIL arst_outs: got %h expected 0", all_outs()); end
    tick();
    rst_n = 1'b1;
    tick();
    tests++; if (bus.o_busy !== 1'b0 || bus.o_trk_pixelVAL !== 1'b0) begin fails++; $display("FAIL arst_after: got busy %b pv %b expected 0 0", bus.o_busy, bus.o_trk_pixelVAL); end
  endtask

  initial begin
    bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_skip = '0;
    bus.i_pix_rgb = '0; bus.i_pix_valid = 1'b0; bus.i_pix_sof = 1'b0;
    bus.i_trk_pointH = '0; bus.i_trk_pointV = '0; bus.i_trk_valid = 1'b0;
    sof_map = '{default: 1'b0};
    clear_obs();
    test_reset();
    test_basic();
    test_junk_sof();
    test_skip();
    test_misaligned();
    test_timeout();
    test_stop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
